// File: rtl/efpga_ccff_loader.sv
// Configuration-chain loader for the eFPGA wrapper: streams 32-bit bitstream words
// LSB-first into ccff_head after a programming reset and captures the last 32 tail bits.
module efpga_ccff_loader #(
   parameter int LEN_W      = 20,
   parameter int RST_CYCLES = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [LEN_W-1:0] chain_len_i,
   input  logic [31:0]      cfg_data_i,
   input  logic             cfg_valid_i,
   output logic             cfg_ready_o,
   output logic             ccff_head_o,
   input  logic             ccff_tail_i,
   output logic             prog_clk_en_o,
   output logic             prog_reset_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [31:0]      tail_word_o,
   output logic [1:0]       dbg_state_o
);

   localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRST = 2'd1,
      LOAD = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] rst_cnt;
   logic [LEN_W-1:0] remaining;
   logic [31:0]      word_q;
   logic [4:0]       bit_idx;
   logic             have_word;
   logic             accept;

   // Stream handshake: a word transfers on every clock edge where cfg_valid_i and
   // cfg_ready_o are both high; ready is decoded from registers only, so it never
   // depends on valid in the same cycle. Valid outside LOAD is left pending.
   assign accept      = cfg_valid_i & cfg_ready_o;
   assign busy_o      = (state != IDLE);
   assign dbg_state_o = state;

   always_comb begin
      state_nxt     = state;
      cfg_ready_o   = 1'b0;
      ccff_head_o   = 1'b0;
      prog_clk_en_o = 1'b0;
      prog_reset_o  = 1'b0;
      done_o        = 1'b0;
      case (state)
         IDLE: begin
            if (start_i && (chain_len_i != '0)) state_nxt = PRST;
         end
         PRST: begin
            prog_reset_o = 1'b1;
            if (rst_cnt == '0) state_nxt = LOAD;
         end
         LOAD: begin
            // Refill one cycle early while the current word's last bit shifts out,
            // unless that bit is the final one of the whole chain.
            cfg_ready_o   = !have_word || ((bit_idx == 5'd31) && (remaining > LEN_W'(1)));
            prog_clk_en_o = have_word;
            ccff_head_o   = have_word & word_q[bit_idx];
            if (have_word && (remaining == LEN_W'(1))) state_nxt = DONE;
         end
         DONE: begin
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (abort_i) state_nxt = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         rst_cnt     <= '0;
         remaining   <= '0;
         word_q      <= '0;
         bit_idx     <= '0;
         have_word   <= 1'b0;
         err_o       <= 1'b0;
         tail_word_o <= '0;
      end else begin
         state <= state_nxt;
         if (abort_i) begin
            have_word <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_i) begin
                     if (chain_len_i != '0) begin
                        remaining   <= chain_len_i;
                        err_o       <= 1'b0;
                        tail_word_o <= '0;
                        rst_cnt     <= CNT_W'(RST_CYCLES - 1);
                     end else begin
                        err_o <= 1'b1;
                     end
                  end
               end
               PRST: begin
                  if (rst_cnt != '0) rst_cnt <= rst_cnt - CNT_W'(1);
               end
               LOAD: begin
                  if (have_word) begin
                     tail_word_o <= {ccff_tail_i, tail_word_o[31:1]};
                     remaining   <= remaining - LEN_W'(1);
                     bit_idx     <= bit_idx + 5'd1;
                     if ((bit_idx == 5'd31) || (remaining == LEN_W'(1))) have_word <= 1'b0;
                  end
                  // A same-cycle refill overrides the end-of-word clear above.
                  if (accept) begin
                     word_q    <= cfg_data_i;
                     bit_idx   <= '0;
                     have_word <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_efpga_ccff_loader.sv
// Directed bench for efpga_ccff_loader: timing of reset/load/done, bit order,
// partial words, stalls, tail capture, reset, error and abort behaviour.
module tb_efpga_ccff_loader;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i;
   logic        abort_i;
   logic [19:0] chain_len_i;
   logic [31:0] cfg_data_i;
   logic        cfg_valid_i;
   logic        cfg_ready_o;
   logic        ccff_head_o;
   logic        ccff_tail_i;
   logic        prog_clk_en_o;
   logic        prog_reset_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic [31:0] tail_word_o;
   logic [1:0]  dbg_state_o;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] words_q[$];
   logic        head_q[$];
   int          n_en, n_prst, n_acc, n_done, done_cyc, first_acc, gap_cycles;

   efpga_ccff_loader #(.LEN_W(20), .RST_CYCLES(4)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .start_i       (start_i),
      .abort_i       (abort_i),
      .chain_len_i   (chain_len_i),
      .cfg_data_i    (cfg_data_i),
      .cfg_valid_i   (cfg_valid_i),
      .cfg_ready_o   (cfg_ready_o),
      .ccff_head_o   (ccff_head_o),
      .ccff_tail_i   (ccff_tail_i),
      .prog_clk_en_o (prog_clk_en_o),
      .prog_reset_o  (prog_reset_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .err_o         (err_o),
      .tail_word_o   (tail_word_o),
      .dbg_state_o   (dbg_state_o)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pack(input int from, input int n);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r[i] = head_q[from + i];
      return r;
   endfunction

   // Drives a full load from words_q. After each accept, the next word is held back
   // until 32+gap cycles later when gap>0; tail_pat is fed LSB-first on the last 32 shifts.
   task automatic run_load(input logic [19:0] len, input int gap,
                           input logic [31:0] tail_pat, input int max_cyc);
      int next_ok;
      int tail_base;
      head_q.delete();
      n_en = 0; n_prst = 0; n_acc = 0; n_done = 0;
      done_cyc = -1; first_acc = -1; gap_cycles = 0; next_ok = 0;
      tail_base = int'(len) - 32;
      chain_len_i = len;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int c = 1; c <= max_cyc; c++) begin
         if (prog_reset_o) n_prst++;
         if (done_o) begin
            n_done++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (prog_clk_en_o) begin
            head_q.push_back(ccff_head_o);
            ccff_tail_i = (n_en >= tail_base) ? tail_pat[n_en - tail_base] : 1'b0;
            n_en++;
         end else begin
            ccff_tail_i = 1'b0;
            if (n_en > 0 && n_en < int'(len) && busy_o && !done_o) gap_cycles++;
         end
         cfg_valid_i = (words_q.size() > 0) && (c >= next_ok);
         cfg_data_i  = cfg_valid_i ? words_q[0] : 32'h0;
         if (cfg_valid_i && cfg_ready_o) begin
            n_acc++;
            if (first_acc < 0) first_acc = c;
            void'(words_q.pop_front());
            next_ok = (gap > 0) ? c + 32 + gap : 0;
         end
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
         step();
      end
      cfg_valid_i = 1'b0;
      cfg_data_i  = 32'h0;
      ccff_tail_i = 1'b0;
   endtask

   initial begin
      int dn;
      rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; chain_len_i = '0;
      cfg_data_i = '0; cfg_valid_i = 1'b0; ccff_tail_i = 1'b0;
      #23 rst_ni = 1'b1;
      step();

      // reset state
      check("rst_ready",   32'(cfg_ready_o),   32'h0);
      check("rst_head",    32'(ccff_head_o),   32'h0);
      check("rst_clk_en",  32'(prog_clk_en_o), 32'h0);
      check("rst_preset",  32'(prog_reset_o),  32'h0);
      check("rst_busy",    32'(busy_o),        32'h0);
      check("rst_done",    32'(done_o),        32'h0);
      check("rst_err",     32'(err_o),         32'h0);
      check("rst_tail",    tail_word_o,        32'h0);
      check("rst_state",   32'(dbg_state_o),   32'h0);

      // basic: 32 bits, one word, done at cycle 4+2+32
      words_q = '{32'hA5A5_0F0F};
      run_load(20'd32, 0, 32'h1234_5678, 200);
      check("basic_prst_cycles", 32'(n_prst),     32'd4);
      check("basic_first_acc",   32'(first_acc),  32'd5);
      check("basic_shifts",      32'(n_en),       32'd32);
      check("basic_first_nib",   pack(0, 8),      32'h0000_000F);
      check("basic_bits",        pack(0, 32),     32'hA5A5_0F0F);
      check("basic_done_cyc",    32'(done_cyc),   32'd38);
      check("basic_done_cnt",    32'(n_done),     32'd1);
      check("basic_gaps",        32'(gap_cycles), 32'd0);
      check("basic_tail",        tail_word_o,     32'h1234_5678);
      check("basic_idle_busy",   32'(busy_o),     32'h0);

      // partial last word: 40 bits, third word must stay pending
      words_q = '{32'hFFFF_FFFF, 32'h0000_00AA, 32'h5555_5555};
      run_load(20'd40, 0, 32'hCAFE_F00D, 200);
      check("part_shifts",   32'(n_en),           32'd40);
      check("part_word0",    pack(0, 32),         32'hFFFF_FFFF);
      check("part_last8",    pack(32, 8),         32'h0000_00AA);
      check("part_accepts",  32'(n_acc),          32'd2);
      check("part_pending",  32'(words_q.size()), 32'd1);
      check("part_done_cyc", 32'(done_cyc),       32'd46);
      check("part_tail",     tail_word_o,         32'hCAFE_F00D);
      words_q.delete();

      // stall: 10-cycle gap before second word
      words_q = '{32'h1357_9BDF, 32'h2468_ACE0};
      run_load(20'd64, 10, 32'hDEAD_BEEF, 300);
      check("stall_shifts",   32'(n_en),       32'd64);
      check("stall_gap",      32'(gap_cycles), 32'd10);
      check("stall_word0",    pack(0, 32),     32'h1357_9BDF);
      check("stall_word1",    pack(32, 32),    32'h2468_ACE0);
      check("stall_accepts",  32'(n_acc),      32'd2);
      check("stall_done_cnt", 32'(n_done),     32'd1);
      check("stall_done_cyc", 32'(done_cyc),   32'd80);
      check("stall_tail",     tail_word_o,     32'hDEAD_BEEF);

      // asynchronous reset mid-LOAD
      chain_len_i = 20'd32; start_i = 1'b1; cfg_valid_i = 1'b1;
      cfg_data_i = 32'hFFFF_FFFF; ccff_tail_i = 1'b1;
      step();
      start_i = 1'b0;
      repeat (12) step();
      check("mid_clk_en",  32'(prog_clk_en_o), 32'h1);
      check("mid_tail",    tail_word_o,        32'hFE00_0000);
      #2 rst_ni = 1'b0;
      #1;
      check("arst_clk_en", 32'(prog_clk_en_o), 32'h0);
      check("arst_head",   32'(ccff_head_o),   32'h0);
      check("arst_ready",  32'(cfg_ready_o),   32'h0);
      check("arst_busy",   32'(busy_o),        32'h0);
      check("arst_tail",   tail_word_o,        32'h0);
      cfg_valid_i = 1'b0; ccff_tail_i = 1'b0;
      #10 rst_ni = 1'b1;
      step();
      check("post_rst_busy",  32'(busy_o),      32'h0);
      check("post_rst_state", 32'(dbg_state_o), 32'h0);

      // zero-length start flags an error
      chain_len_i = 20'd0; start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("len0_err",  32'(err_o),  32'h1);
      check("len0_busy", 32'(busy_o), 32'h0);

      // valid start clears err; start mid-load ignored; abort returns to IDLE
      chain_len_i = 20'd32; start_i = 1'b1; cfg_valid_i = 1'b1; cfg_data_i = 32'h0F0F_0F0F;
      step();
      start_i = 1'b0;
      check("restart_err_clr", 32'(err_o), 32'h0);
      repeat (7) step();
      chain_len_i = 20'd0; start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("busy_start_ign", 32'(err_o),         32'h0);
      check("abort_pre_en",   32'(prog_clk_en_o), 32'h1);
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      check("abort_busy",   32'(busy_o),        32'h0);
      check("abort_clk_en", 32'(prog_clk_en_o), 32'h0);
      check("abort_state",  32'(dbg_state_o),   32'h0);
      check("abort_err",    32'(err_o),         32'h0);
      dn = 0;
      for (int i = 0; i < 50; i++) begin
         if (done_o) dn++;
         step();
      end
      cfg_valid_i = 1'b0;
      check("abort_no_done", 32'(dn), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
